// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Per-stage valid/ready/flush control for the in-order MIPS pipe.
//            Handles stalls and serialization. Flushes are precise and pass
//            through a drain FSM (RUN/DRAIN/HOLD) that has a timeout.
//            Optional performance counters: PIPE_HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int unsigned                NUM_STAGES    = 5,
  parameter logic [NUM_STAGES-1:0]      FLUSH_MASK    = 5'b11110,
  parameter logic [NUM_STAGES-1:0]      BARRIER_MASK  = 5'b00101,
  parameter int unsigned                HOLD_CYCLES   = 1,
  parameter int unsigned                DRAIN_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_STAGES-1:0] stage_busy,
  input  logic [NUM_STAGES-1:0] stage_hazard,
  input  logic                  flush_req,
  input  logic                  serialize_req,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_flush_n,
  output logic                  drain_timeout,
`ifdef PIPE_HAZARD_PERF_CNT_EN
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count,
`endif
  output logic [1:0]            ctrl_state
);

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_MAX  = {DW{1'b1}};
  localparam logic [3:0]    HOLD_INIT  = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state, next_state;
  logic [DW-1:0]         drain_cnt;
  logic [3:0]            hold_cnt;
  logic                  barrier_busy;
  logic                  fire;
  logic                  timeout;
  logic                  freeze;
  logic [NUM_STAGES-1:0] own_valid, own_ready, vld, rdy;

  // Flush decision and next-state logic for the drain FSM.
  always_comb begin
    barrier_busy = |(stage_busy & BARRIER_MASK);
    fire         = 1'b0;
    timeout      = 1'b0;
    freeze       = 1'b0;
    next_state   = state;
    case (state)
      RUN: begin
        if (flush_req) begin
          if (!barrier_busy) begin
            fire = 1'b1;
          end else begin
            freeze     = 1'b1;
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!flush_req) begin
          freeze     = 1'b1;
          next_state = RUN;
        end else if (!barrier_busy) begin
          fire = 1'b1;
        end else if (drain_cnt == DRAIN_LAST) begin
          fire    = 1'b1;
          timeout = 1'b1;
        end else begin
          freeze = 1'b1;
        end
      end
      HOLD: begin
        // A new flush_req waits until we are back in RUN.
        if (hold_cnt <= 4'd1) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
    if (fire) next_state = (HOLD_CYCLES == 0) ? RUN : HOLD;
  end

  // State register and saturating drain/hold counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RUN;
      drain_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state == DRAIN && next_state == DRAIN) begin
        if (drain_cnt != DRAIN_MAX) drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end
      if (fire) begin
        hold_cnt <= HOLD_INIT;
      end else if (state == HOLD && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // Per-stage own terms, the back-pressure chain and the reset gating of outputs.
  always_comb begin
    own_valid = ~(stage_busy | stage_hazard);
    own_ready = ~(stage_busy | stage_hazard);
    if (state == RUN && !fire && serialize_req) begin
      own_valid[0] = 1'b0;
      own_ready[0] = 1'b0;
    end
    if (freeze) own_ready[NUM_STAGES-1] = 1'b0;
    if (fire) begin
      own_valid = own_valid & ~FLUSH_MASK;
      own_ready = own_ready | FLUSH_MASK;
    end
    rdy                 = '0;
    rdy[NUM_STAGES-1]   = own_ready[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      rdy[i] = own_ready[i] & rdy[i+1];
    end
    vld = own_valid;
    if (freeze) vld = vld & ~FLUSH_MASK;
    if (state == HOLD) vld[0] = 1'b0;

    if (!resetn) begin
      stage_valid   = '0;
      stage_ready   = '0;
      stage_flush_n = '0;
      drain_timeout = 1'b0;
    end else begin
      stage_valid   = vld;
      stage_ready   = rdy;
      stage_flush_n = fire ? ~FLUSH_MASK : {NUM_STAGES{1'b1}};
      drain_timeout = timeout;
    end
    ctrl_state = state;
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!stage_ready[0] && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 1'b1;
      if (fire && flush_count != 16'hFFFF)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl. It uses a
//            default instance and a second one with DRAIN_TIMEOUT=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] stage_busy, stage_hazard;
  logic       flush_req, serialize_req;

  logic [4:0] valid, ready, flush_n;
  logic       tmo;
  logic [1:0] state;
  logic [4:0] t_valid, t_ready, t_flush_n;
  logic       t_tmo;
  logic [1:0] t_state;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, t_stall_cycles;
  logic [15:0] flush_count, t_flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .resetn(resetn), .stage_busy(stage_busy), .stage_hazard(stage_hazard),
    .flush_req(flush_req), .serialize_req(serialize_req),
    .stage_valid(valid), .stage_ready(ready), .stage_flush_n(flush_n),
    .drain_timeout(tmo),
`ifdef PIPE_HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .ctrl_state(state)
  );

  pipeline_hazard_ctrl #(.DRAIN_TIMEOUT(4)) dut_t (
    .clk(clk), .resetn(resetn), .stage_busy(stage_busy), .stage_hazard(stage_hazard),
    .flush_req(flush_req), .serialize_req(serialize_req),
    .stage_valid(t_valid), .stage_ready(t_ready), .stage_flush_n(t_flush_n),
    .drain_timeout(t_tmo),
`ifdef PIPE_HAZARD_PERF_CNT_EN
    .stall_cycles(t_stall_cycles), .flush_count(t_flush_count),
`endif
    .ctrl_state(t_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stage_busy    = '0;
    stage_hazard  = '0;
    flush_req     = 1'b0;
    serialize_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    #2;
    chk("rst_valid",   valid,   5'h00);
    chk("rst_ready",   ready,   5'h00);
    chk("rst_flush_n", flush_n, 5'h00);
    chk("rst_tmo",     tmo,     1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // First cycle after release, idle inputs.
    tick();
    chk("idle_valid",   valid,   5'h1F);
    chk("idle_ready",   ready,   5'h1F);
    chk("idle_flush_n", flush_n, 5'h1F);
    chk("idle_state",   state,   2'd0);

    // Decode hazard stalls stages 0..1 only.
    tick(); stage_hazard = 5'b00010; #1;
    chk("haz_valid", valid, 5'b11101);
    chk("haz_ready", ready, 5'b11100);

    // Clean flush: fires immediately, then one HOLD cycle.
    tick(); stage_hazard = '0; flush_req = 1'b1; #1;
    chk("fl_flush_n", flush_n, 5'b00001);
    chk("fl_valid",   valid,   5'b00001);
    chk("fl_ready",   ready,   5'h1F);
    chk("fl_state",   state,   2'd0);
    tick(); #1;  // HOLD, flush_req still high but must be ignored
    chk("hold_state",   state,   2'd2);
    chk("hold_flush_n", flush_n, 5'h1F);
    chk("hold_valid",   valid,   5'b11110);
    chk("hold_ready",   ready,   5'h1F);
    tick(); #1;  // back in RUN: pending flush re-evaluated and fires
    chk("refl_state",   state,   2'd0);
    chk("refl_flush_n", flush_n, 5'b00001);
    tick(); flush_req = 1'b0; #1;
    chk("hold2_state", state, 2'd2);
    tick(); #1;
    chk("run_state", state, 2'd0);
    chk("run_valid", valid, 5'h1F);

    // Drain while barrier stage 2 is busy for 3 cycles.
    tick(); flush_req = 1'b1; stage_busy = 5'b00100; #1;
    chk("dr0_state",   state,   2'd0);
    chk("dr0_valid",   valid,   5'b00001);
    chk("dr0_ready",   ready,   5'h00);
    chk("dr0_flush_n", flush_n, 5'h1F);
    for (int k = 1; k <= 2; k++) begin
      tick(); #1;
      chk("dr_state",   state,   2'd1);
      chk("dr_valid",   valid,   5'b00001);
      chk("dr_ready",   ready,   5'h00);
      chk("dr_flush_n", flush_n, 5'h1F);
    end
    tick(); stage_busy = '0; #1;
    chk("drf_state",   state,   2'd1);
    chk("drf_flush_n", flush_n, 5'b00001);
    chk("drf_tmo",     tmo,     1'b0);
    chk("drf_ready",   ready,   5'h1F);
    tick(); flush_req = 1'b0; #1;
    chk("drh_state", state, 2'd2);
    tick(); #1;
    chk("drr_state", state, 2'd0);

    // Timeout: busy[0] stuck, DRAIN_TIMEOUT=4 instance forces the flush.
    do_reset();
    tick(); stage_busy = 5'b00001; flush_req = 1'b1; #1;
    chk("to0_state", t_state, 2'd0);
    chk("to0_ready", t_ready, 5'h00);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("to_state",   t_state,   2'd1);
      chk("to_tmo",     t_tmo,     1'b0);
      chk("to_flush_n", t_flush_n, 5'h1F);
    end
    tick(); #1;
    chk("tof_state",   t_state,   2'd1);
    chk("tof_tmo",     t_tmo,     1'b1);
    chk("tof_flush_n", t_flush_n, 5'b00001);
    tick(); #1;
    chk("toh_state", t_state, 2'd2);
    chk("toh_tmo",   t_tmo,   1'b0);
    chk("def_drain", state,   2'd1);
    // Asynchronous reset in the middle of DRAIN.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rstdr_state", state, 2'd0);
    chk("rstdr_tmo",   tmo,   1'b0);
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;

    // Serialize blocks fetch for 2 cycles.
    tick(); serialize_req = 1'b1; #1;
    chk("ser0_valid", valid, 5'b11110);
    chk("ser0_ready", ready, 5'b11110);
    tick(); #1;
    chk("ser1_valid", valid, 5'b11110);
    chk("ser1_ready", ready, 5'b11110);
    tick(); serialize_req = 1'b0; #1;
    chk("ser_end_ready", ready, 5'h1F);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 32'd2);
    chk("flush_count",  flush_count,  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
